// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one W-bit ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_OPCHECK_EN: flag opcodes 6-15 as illegal and force an error response.
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] alu_dat1,
    output logic [W-1:0] alu_dat2,
    output logic [3:0]   alu_control,
    input  logic [W-1:0] alu_result,
    input  logic         alu_z,
    input  logic         alu_n,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_z,
    output logic         rsp_n,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_r;
    logic         prio_r;
    logic         id_r;
    logic [3:0]   op_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic         win0_s;
    logic         win1_s;
    logic [3:0]   sel_op_s;
    logic [W-1:0] sel_a_s;
    logic [W-1:0] sel_b_s;

`ifdef ALU_ARB_OPCHECK_EN
    logic illegal_r;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op > 4'd5);
    endfunction
`endif

    // Grant: a lone requester always wins; on contention prio picks the port.
    always_comb begin
        win0_s = 1'b0;
        win1_s = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if (req0_valid && (!req1_valid || !prio_r)) begin
                win0_s = 1'b1;
            end else if (req1_valid) begin
                win1_s = 1'b1;
            end else begin
                win0_s = 1'b0;
                win1_s = 1'b0;
            end
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
    end

    // Operand mux feeding the request latch.
    always_comb begin
        sel_op_s = req0_op;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (win1_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    assign req0_ready  = win0_s;
    assign req1_ready  = win1_s;
    assign alu_dat1    = a_r;
    assign alu_dat2    = b_r;
    assign alu_control = op_r;

`ifndef ALU_ARB_OPCHECK_EN
    assign rsp_err = 1'b0;
`endif

    // Arbitration FSM, request latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            prio_r     <= 1'b0;
            id_r       <= 1'b0;
            op_r       <= 4'd0;
            a_r        <= '0;
            b_r        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            illegal_r  <= 1'b0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (win0_s || win1_s) begin
                        id_r    <= win1_s;
                        op_r    <= sel_op_s;
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        prio_r  <= win0_s;
                        state_r <= EXEC;
`ifdef ALU_ARB_OPCHECK_EN
                        illegal_r <= op_illegal(sel_op_s);
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_r;
                    state_r   <= RESP;
`ifdef ALU_ARB_OPCHECK_EN
                    if (illegal_r) begin
                        rsp_result <= {W{1'b1}};
                        rsp_z      <= 1'b0;
                        rsp_n      <= 1'b1;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_z      <= alu_z;
                        rsp_n      <= alu_n;
                        rsp_err    <= 1'b0;
                    end
`else
                    rsp_result <= alu_result;
                    rsp_z      <= alu_z;
                    rsp_n      <= alu_n;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter; the bench itself plays the shared ALU.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 4'd0, req1_op = 4'd0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0] alu_dat1, alu_dat2, alu_result;
    logic [3:0]   alu_control;
    logic         alu_z, alu_n;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_z, rsp_n, rsp_err;
    logic [W-1:0] rsp_result;

    int vectors = 0;
    int miscompares = 0;
    logic exp_err;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: unknown opcodes return all ones.
    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_dat1 + alu_dat2;
            4'd1:    alu_result = alu_dat1 - alu_dat2;
            4'd2:    alu_result = alu_dat1 * alu_dat2;
            4'd3:    alu_result = alu_dat1 | alu_dat2;
            4'd4:    alu_result = alu_dat1 << alu_dat2;
            4'd5:    alu_result = alu_dat1 >> alu_dat2;
            default: alu_result = 32'hFFFF_FFFF;
        endcase
        alu_z = (alu_result == 32'd0);
        alu_n = alu_result[W-1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [W-1:0] res,
                           input logic z, input logic n);
        chk({tag, " valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " id"}, {31'd0, rsp_id}, {31'd0, id});
        chk({tag, " result"}, rsp_result, res);
        chk({tag, " z"}, {31'd0, rsp_z}, {31'd0, z});
        chk({tag, " n"}, {31'd0, rsp_n}, {31'd0, n});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " rsp_id"}, {31'd0, rsp_id}, 32'd0);
        chk({tag, " rsp_result"}, rsp_result, 32'd0);
        chk({tag, " rsp_z"}, {31'd0, rsp_z}, 32'd0);
        chk({tag, " rsp_n"}, {31'd0, rsp_n}, 32'd0);
        chk({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, " alu_dat1"}, alu_dat1, 32'd0);
        chk({tag, " alu_dat2"}, alu_dat2, 32'd0);
        chk({tag, " alu_control"}, {28'd0, alu_control}, 32'd0);
        chk({tag, " ready0"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, " ready1"}, {31'd0, req1_ready}, 32'd0);
    endtask

    initial begin
`ifdef ALU_ARB_OPCHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset state
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single requester: 5 + 7
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        chk("t1 ready0", {31'd0, req0_ready}, 32'd1);
        chk("t1 ready1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("t1 exec ready0", {31'd0, req0_ready}, 32'd0);
        chk("t1 exec rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1 alu_dat1", alu_dat1, 32'd5);
        chk("t1 alu_dat2", alu_dat2, 32'd7);
        chk("t1 alu_control", {28'd0, alu_control}, 32'd0);
        req0_valid = 1'b0;
        step();
        chk_rsp("t1", 1'b0, 32'd12, 1'b0, 1'b0);
        step();
        chk("t1 idle rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Contention from reset: prio alternates over 4 pairs
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd6; req1_b = 32'd7;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t2 ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2 ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            step();
            if (i % 2 == 0) chk_rsp("t2 p0", 1'b0, 32'd0, 1'b1, 1'b0);
            else            chk_rsp("t2 p1", 1'b1, 32'd42, 1'b0, 1'b0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure on a port-1 shift: 1 << 31
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd1; req1_b = 32'd31;
        #1;
        chk("t3 ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        step();
        chk_rsp("t3", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_rsp("t3 hold", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
            chk("t3 hold ready0", {31'd0, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3 release ready0", {31'd0, req0_ready}, 32'd0);
        step();
        chk("t3 idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t3 accept ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk_rsp("t3 next", 1'b0, 32'd12, 1'b0, 1'b0);
        step();

        // Reset during EXEC of 0xF0 | 0x0F
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'hF0; req0_b = 32'h0F;
        #1;
        chk("t4 ready0", {31'd0, req0_ready}, 32'd1);
        step();
        chk("t4 exec alu_dat1", alu_dat1, 32'hF0);
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_outputs("t4 rst");
        rst = 1'b0;
        step();
        chk("t4 no rsp", {31'd0, rsp_valid}, 32'd0);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd10; req1_b = 32'd3;
        #1;
        chk("t4 prio ready0", {31'd0, req0_ready}, 32'd1);
        chk("t4 prio ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk_rsp("t4 after", 1'b0, 32'd12, 1'b0, 1'b0);
        step();

        // Illegal opcode 9
        req0_valid = 1'b1; req0_op = 4'd9; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        chk("t5 ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("t5 alu_control", {28'd0, alu_control}, 32'd9);
        step();
        chk_rsp("t5", 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("t5 err", {31'd0, rsp_err}, {31'd0, exp_err});
        step();

        // Legal op after the illegal one clears the error
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        chk("t6 ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        chk_rsp("t6", 1'b1, 32'd2, 1'b0, 1'b0);
        chk("t6 err", {31'd0, rsp_err}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU (add/sub/mul/or/lsl/lsr) between two requesters, e.g. the calculator command decoder (port 0) and the display/format unit (port 1). Each request is accepted through a valid/ready handshake, latched, executed on the ALU for one cycle, and returned as a registered result plus Z/N flags tagged with the requester ID. Arbitration is round-robin; the block owns the ALU's input pins exclusively.

## Interface
Parameters:
- `W`, 32, datapath width; must match ALU width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands.
- `alu_dat1`, `alu_dat2`  out  W  to the ALU, from latched operands.
- `alu_control`  out  4  to the ALU, from latched opcode.
- `alu_result`  in  W  from the ALU.
- `alu_z`, `alu_n`  in  1  flags from the ALU.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  requester that issued the op.
- `rsp_result`  out  W  registered result.
- `rsp_z`, `rsp_n`  out  1  registered flags.
- `rsp_err`  out  1  illegal opcode (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among asserted `reqX_valid`. If one is asserted, it wins. If both are asserted, the winner is the port indicated by the round-robin pointer `prio`.
  - The winner's `reqX_ready` = 1, combinational and in IDLE only. The loser's ready = 0.
  - On handshake: latch op/a/b and `id`, set `prio` to the non-winning port, go to EXEC.
- EXEC: `alu_*` outputs are driven from the latch. At the clock edge, capture `alu_result`, `alu_z`, `alu_n` into the `rsp_*` registers and go to RESP.
- RESP: `rsp_valid` = 1. All `rsp_*` outputs stay stable until `rsp_ready` = 1, then go to IDLE. No request is accepted in RESP or EXEC.
- `alu_*` outputs keep the last latched values outside EXEC. They are never driven from `reqX_*` directly.
- Operands pass through unmodified. Shift amounts are the full `b`. Mul result is the low W bits.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_z`=0, `rsp_n`=0, `rsp_err`=0, `reqX_ready`=0, `alu_dat1`=0, `alu_dat2`=0, `alu_control`=0, `prio`=0.

## Timing
- Cycle N: handshake in IDLE.
- Cycle N+1: EXEC.
- Cycle N+2: `rsp_valid`=1.
- Latency is 2 cycles from acceptance to response valid.
- With `rsp_ready` held at 1, throughput is one op per 3 cycles. RESP→IDLE and the next acceptance happen on consecutive cycles.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely. Requesters see ready=0 for the whole time.
- `rsp_ready` has no effect outside RESP.
- Deasserting `reqX_valid` before acceptance is legal. Nothing is latched.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, state returns to IDLE, `prio` returns to 0, and all outputs return to their reset values on the next edge.
- A single requester alone is granted every time, regardless of `prio`. `prio` still updates to the other port.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - Opcodes 6–15 are detected in IDLE at acceptance.
  - The op still passes through EXEC, but `rsp_result`=0xFFFFFFFF, `rsp_z`=0, `rsp_n`=1, `rsp_err`=1. ALU outputs are ignored.
  - `rsp_err` clears on the next accepted legal op.
- `ALU_ARB_OPCHECK_EN` undefined:
  - All opcodes are forwarded to the ALU unchanged.
  - `rsp_*` are captured from the ALU as for a legal op.
  - `rsp_err` is tied to 0.

## Test plan
- Port 0 only, op=0, a=5, b=7 → `req0_ready` in cycle N; `rsp_valid` in N+2 with result=12, z=0, n=0, id=0.
- Both ports valid from reset: port 0 op=1 a=3 b=3; port 1 op=2 a=6 b=7. → Port 0 is granted first: result=0, z=1, id=0. Port 1 follows: result=42, id=1. `prio` alternates across 4 back-to-back pairs.
- `rsp_ready`=0 for 5 cycles after a port 1 op=4 a=1 b=31 → `rsp_result`=0x80000000, n=1, held stable. `req0_ready` stays 0 while `req0_valid`=1. The op is accepted on the cycle after `rsp_ready`=1.
- `rst`=1 during EXEC of op=3 a=0xF0 b=0x0F → no `rsp_valid`. All outputs are at reset values on the next edge. A new request completes normally afterward.
- Op=9 a=1 b=1. With the macro: result=0xFFFFFFFF, err=1, n=1. Without the macro: err=0 and the captured result equals the ALU's output (0xFFFFFFFF).
